// File: rtl/timer_display.sv
// timer_display: binary MM:SS from the countdown timer to four active-low
// seven-segment digit drives, with a sequential double-dabble and an expiry blink.
module timer_display #(
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       timer_end,
  output logic [6:0] seg_m1,
  output logic [6:0] seg_m0,
  output logic [6:0] seg_s1,
  output logic [6:0] seg_s0,
  output logic       busy
);
  localparam int CW = $clog2(BLINK_CYCLES);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t        state_q, state_d;
  logic [5:0]    last_min_q, last_min_d, last_sec_q, last_sec_d;
  logic [5:0]    work_min_q, work_min_d, work_sec_q, work_sec_d;
  logic [7:0]    bcd_min_q, bcd_min_d, bcd_sec_q, bcd_sec_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   dig_q, dig_d;
  logic [CW-1:0] blk_q, blk_d;
  logic          blank_q, blank_d, busy_q, blk_wrap;
  logic [27:0]   seg_q, seg_d;

  function automatic logic [7:0] adj(input logic [7:0] b);
    return {b[7:4] >= 4'd5 ? b[7:4] + 4'd3 : b[7:4], b[3:0] >= 4'd5 ? b[3:0] + 4'd3 : b[3:0]};
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h40;
      4'd1: enc = 7'h79;
      4'd2: enc = 7'h24;
      4'd3: enc = 7'h30;
      4'd4: enc = 7'h19;
      4'd5: enc = 7'h12;
      4'd6: enc = 7'h02;
      4'd7: enc = 7'h78;
      4'd8: enc = 7'h00;
      4'd9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  assign blk_wrap = blk_q == CW'(BLINK_CYCLES - 1);

  always_comb begin
    state_d    = state_q;
    last_min_d = last_min_q;
    last_sec_d = last_sec_q;
    work_min_d = work_min_q;
    work_sec_d = work_sec_q;
    bcd_min_d  = bcd_min_q;
    bcd_sec_d  = bcd_sec_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    case (state_q)
      IDLE: if ({min_in, sec_in} != {last_min_q, last_sec_q}) begin
        work_min_d = min_in;
        work_sec_d = sec_in;
        bcd_min_d  = '0;
        bcd_sec_d  = '0;
        cnt_d      = 3'd6;
        state_d    = SHIFT;
      end
      SHIFT: begin
        // work rotates rather than shifts, so after six steps it holds the captured value again
        {bcd_min_d, work_min_d} = 14'({adj(bcd_min_q), work_min_q[5], work_min_q[4:0], work_min_q[5]});
        {bcd_sec_d, work_sec_d} = 14'({adj(bcd_sec_q), work_sec_q[5], work_sec_q[4:0], work_sec_q[5]});
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd1 ? COMMIT : SHIFT;
      end
      COMMIT: begin
        dig_d      = {bcd_min_q, bcd_sec_q};
        last_min_d = work_min_q;
        last_sec_d = work_sec_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    blk_d   = timer_end ? (blk_wrap ? '0 : blk_q + 1'b1) : '0;
    blank_d = timer_end ? blank_q ^ blk_wrap : 1'b0;
    for (int i = 0; i < 4; i++) seg_d[i*7 +: 7] = blank_q ? 7'h7F : enc(dig_q[i*4 +: 4]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_min_q <= '0;
      last_sec_q <= '0;
      work_min_q <= '0;
      work_sec_q <= '0;
      bcd_min_q  <= '0;
      bcd_sec_q  <= '0;
      cnt_q      <= '0;
      dig_q      <= '0;
      blk_q      <= '0;
      blank_q    <= 1'b0;
      busy_q     <= 1'b0;
      seg_q      <= {4{7'h40}};
    end else begin
      state_q    <= state_d;
      last_min_q <= last_min_d;
      last_sec_q <= last_sec_d;
      work_min_q <= work_min_d;
      work_sec_q <= work_sec_d;
      bcd_min_q  <= bcd_min_d;
      bcd_sec_q  <= bcd_sec_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      blk_q      <= blk_d;
      blank_q    <= blank_d;
      busy_q     <= state_d != IDLE;
      seg_q      <= seg_d;
    end
  end

  assign {seg_m1, seg_m0, seg_s1, seg_s0} = seg_q;
  assign busy = busy_q;
endmodule
